jts16_snd_romarb: RTL

Arbiter that shares one 8-bit SDRAM read slot between the sound Z80 program ROM fetch and the ADPCM sample ROM fetch. It sits between the sound CPU/PCM datapath and the SDRAM controller. Each requester has a one-entry hit cache, so repeated reads of the same byte never reach SDRAM. Misses are served one at a time, in round-robin order.

---
 rtl/jts16_snd_romarb.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/jts16_snd_romarb.sv
// Sound ROM arbiter: shares one SDRAM byte slot between the Z80 program
// ROM and the ADPCM sample ROM, each fronted by a one-entry hit cache.
module jts16_snd_romarb #(
  parameter logic [17:0] PCM_BASE = 18'h08000,
  parameter int          CPU_AW   = 15,
  parameter int          PCM_AW   = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CPU_AW-1:0] rom_addr,
  input  logic              rom_cs,
  output logic [7:0]        rom_data,
  output logic              rom_ok,
  input  logic [PCM_AW-1:0] pcm_addr,
  input  logic              pcm_cs,
  output logic [7:0]        pcm_data,
  output logic              pcm_ok,
  output logic [17:0]       mem_addr,
  output logic              mem_cs,
  input  logic [7:0]        mem_data,
  input  logic              mem_ok
);

  localparam int TW = (PCM_AW > CPU_AW) ? PCM_AW : CPU_AW;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t st, st_nx;

  logic              cpu_vld;
  logic [CPU_AW-1:0] cpu_tag;
  logic [7:0]        cpu_dat;
  logic              pcm_vld;
  logic [PCM_AW-1:0] pcm_tag;
  logic [7:0]        pcm_dat;

  logic          last_pcm, last_nx;
  logic          armed, armed_nx;
  logic [TW-1:0] fl_tag, tag_nx;
  logic          cs_nx;
  logic [17:0]   addr_nx;
  logic          fill;

  logic cpu_hit, pcm_hit;
  logic cpu_miss, pcm_miss;

  assign cpu_hit  = rom_cs & cpu_vld & (cpu_tag == rom_addr);
  assign pcm_hit  = pcm_cs & pcm_vld & (pcm_tag == pcm_addr);
  assign cpu_miss = rom_cs & ~cpu_hit;
  assign pcm_miss = pcm_cs & ~pcm_hit;

  assign rom_ok   = cpu_hit;
  assign pcm_ok   = pcm_hit;
  assign rom_data = cpu_dat;
  assign pcm_data = pcm_dat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= ST_IDLE;
    else     st <= st_nx;
  end

  always_comb begin
    st_nx    = st;
    cs_nx    = mem_cs;
    addr_nx  = mem_addr;
    last_nx  = last_pcm;
    tag_nx   = fl_tag;
    armed_nx = armed;
    fill     = 1'b0;
    unique case (st)
      ST_IDLE: begin
        if (cpu_miss | pcm_miss) begin
          st_nx    = ST_WAIT;
          cs_nx    = 1'b1;
          armed_nx = 1'b0;
          if (pcm_miss && (!cpu_miss || !last_pcm)) begin
            last_nx = 1'b1;
            tag_nx  = TW'(pcm_addr);
            addr_nx = PCM_BASE + 18'(pcm_addr);
          end else begin
            last_nx = 1'b0;
            tag_nx  = TW'(rom_addr);
            addr_nx = 18'(rom_addr);
          end
        end
      end
      ST_WAIT: begin
        // first WAIT cycle may still see the previous address' ok
        armed_nx = 1'b1;
        if (armed && mem_ok) begin
          fill  = 1'b1;
          cs_nx = 1'b0;
          st_nx = ST_DONE;
        end
      end
      ST_DONE: st_nx = ST_IDLE;
      default: st_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_cs   <= 1'b0;
      mem_addr <= '0;
      last_pcm <= 1'b1;
      armed    <= 1'b0;
      fl_tag   <= '0;
    end else begin
      mem_cs   <= cs_nx;
      mem_addr <= addr_nx;
      last_pcm <= last_nx;
      armed    <= armed_nx;
      fl_tag   <= tag_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_vld <= 1'b0;
      cpu_tag <= '0;
      cpu_dat <= 8'h00;
      pcm_vld <= 1'b0;
      pcm_tag <= '0;
      pcm_dat <= 8'h00;
    end else if (fill) begin
      if (last_pcm) begin
        pcm_vld <= 1'b1;
        pcm_tag <= fl_tag[PCM_AW-1:0];
        pcm_dat <= mem_data;
      end else begin
        cpu_vld <= 1'b1;
        cpu_tag <= fl_tag[CPU_AW-1:0];
        cpu_dat <= mem_data;
      end
    end
  end

endmodule
